// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one-hot columns, senses rows, and debounces
// whole-scan results into a single accepted key code with a one-cycle strobe.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] shift_col,
    output logic [3:0] key_value,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (v[i]) idx = 2'(i);
        return idx;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       hits_q, hits_d;
    logic [3:0]       hit_code_q, hit_code_d;
    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [DB_W-1:0]  cnt_q, cnt_d;
    logic [DB_W-1:0]  rcnt_q, rcnt_d;
    logic [3:0]       key_value_q, key_value_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic       terminal, scan_done;
    logic [2:0] row_pop, total_raw;
    logic [1:0] total;
    logic [3:0] scan_code;
    logic       res_none, res_one;
    logic       accept, release_done;
    logic [3:0] accept_code;
    logic [DB_W-1:0] cnt_inc, rcnt_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q       <= '0;
            col_q       <= 2'd0;
            hits_q      <= 2'd0;
            hit_code_q  <= 4'h0;
            state_q     <= S_IDLE;
            cand_q      <= 4'h0;
            cnt_q       <= '0;
            rcnt_q      <= '0;
            key_value_q <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            div_q       <= div_d;
            col_q       <= col_d;
            hits_q      <= hits_d;
            hit_code_q  <= hit_code_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            rcnt_q      <= rcnt_d;
            key_value_q <= key_value_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    // Column scan: contacts are tallied (saturating at 2) across the four column samples.
    always_comb begin
        terminal  = (div_q == DIV_LAST);
        scan_done = terminal && (col_q == 2'd3);
        div_d     = terminal ? '0 : div_q + DIV_W'(1);
        col_d     = terminal ? col_q + 2'd1 : col_q;
        row_pop   = popcount4(row);
        total_raw = {1'b0, hits_q} + row_pop;
        total     = (total_raw >= 3'd2) ? 2'd2 : total_raw[1:0];
        scan_code = (hits_q == 2'd0) ? key_code(low_index(row), col_q) : hit_code_q;
        hits_d     = hits_q;
        hit_code_d = hit_code_q;
        if (terminal) begin
            hits_d     = scan_done ? 2'd0 : total;
            hit_code_d = scan_done ? 4'h0 : scan_code;
        end
        res_none = (total == 2'd0);
        res_one  = (total == 2'd1);
    end

    // Debounce FSM, advanced only when a full scan resolves.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        cnt_d        = cnt_q;
        rcnt_d       = rcnt_q;
        accept       = 1'b0;
        accept_code  = cand_q;
        release_done = 1'b0;
        cnt_inc      = (cnt_q == DB_TARGET) ? cnt_q : cnt_q + DB_W'(1);
        rcnt_inc     = (rcnt_q == DB_TARGET) ? rcnt_q : rcnt_q + DB_W'(1);
        if (scan_done) begin
            case (state_q)
                S_IDLE: begin
                    if (res_one) begin
                        cand_d = scan_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept      = 1'b1;
                            accept_code = scan_code;
                            state_d     = S_PRESSED;
                            cnt_d       = '0;
                        end else begin
                            state_d = S_DEBOUNCE;
                            cnt_d   = DB_W'(1);
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (!res_one) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (scan_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_TARGET) begin
                            accept  = 1'b1;
                            state_d = S_PRESSED;
                            cnt_d   = '0;
                        end
                    end else begin
                        cand_d = scan_code;
                        cnt_d  = DB_W'(1);
                    end
                end
                S_PRESSED: begin
                    if (res_none) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            release_done = 1'b1;
                            state_d      = S_IDLE;
                            rcnt_d       = '0;
                        end else begin
                            state_d = S_RELEASE;
                            rcnt_d  = DB_W'(1);
                        end
                    end
                end
                default: begin
                    if (res_none) begin
                        rcnt_d = rcnt_inc;
                        if (rcnt_inc == DB_TARGET) begin
                            release_done = 1'b1;
                            state_d      = S_IDLE;
                            rcnt_d       = '0;
                        end
                    end else begin
                        state_d = S_PRESSED;
                        rcnt_d  = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        key_value_d = accept ? accept_code : key_value_q;
        key_valid_d = accept;
        key_held_d  = key_held_q;
        if (accept)
            key_held_d = 1'b1;
        else if (release_done)
            key_held_d = 1'b0;
    end

    assign shift_col = 4'b0001 << col_q;
    assign key_value = key_value_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (16-clock scans).
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] shift_col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c closed
    int cyc = 0;
    int t0 = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] val;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk),
        .reset(reset),
        .row(row),
        .shift_col(shift_col),
        .key_value(key_value),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        row = 4'b0000;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && shift_col[c]) row[r] = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc - t0);
        end
    endtask

    task automatic run_monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (key_valid !== 1'b0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got key_valid=%b key_value=%h at cycle %0d, required no strobe",
                             key_valid, key_value, cyc - t0);
                end else begin
                    e = exp_q.pop_front();
                    if (key_value !== e.val || cyc != e.at) begin
                        errors++;
                        $display("FAIL valid_key: got %h at cycle %0d, required %h at cycle %0d",
                                 key_value, cyc - t0, e.val, e.at - t0);
                    end
                end
            end
        end
    endtask

    task automatic expect_key(input logic [3:0] v, input int rel);
        exp_t e;
        e.val = v;
        e.at  = t0 + rel;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int rel);
        while (cyc < t0 + rel) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
    endtask

    initial begin
        fork
            run_monitor();
        join_none

        // 1: reset state and column stepping
        do_reset();
        chk("rst_shift_col", 32'(shift_col), 32'h1);
        chk("rst_key_value", 32'(key_value), 32'h0);
        chk("rst_key_valid", 32'(key_valid), 32'h0);
        chk("rst_key_held", 32'(key_held), 32'h0);
        wait_to(3);  chk("col0_hold", 32'(shift_col), 32'h1);
        wait_to(4);  chk("col1", 32'(shift_col), 32'h2);
        wait_to(8);  chk("col2", 32'(shift_col), 32'h4);
        wait_to(12); chk("col3", 32'(shift_col), 32'h8);
        wait_to(16); chk("col_wrap", 32'(shift_col), 32'h1);
        wait_to(40);

        // 2: hold '5' for 10 scans, then release
        do_reset();
        keys = 16'(1) << 5;
        expect_key(4'h5, 48);
        wait_to(47);  chk("k5_held_before", 32'(key_held), 32'h0);
        wait_to(48);  chk("k5_held_on", 32'(key_held), 32'h1);
        wait_to(160); keys = '0;
        wait_to(207); chk("k5_held_last", 32'(key_held), 32'h1);
        wait_to(208); chk("k5_held_off", 32'(key_held), 32'h0);
        wait_to(260); chk("k5_drained", 32'(exp_q.size()), 32'h0);

        // 3: bouncing 'F'
        do_reset();
        keys = 16'(1) << 14;
        wait_to(32);  keys = '0;
        wait_to(48);  keys = 16'(1) << 14;
        expect_key(4'hF, 96);
        wait_to(95);  chk("kf_held_before", 32'(key_held), 32'h0);
        wait_to(112); keys = '0;
        chk("kf_value", 32'(key_value), 32'hF);
        wait_to(170); chk("kf_drained", 32'(exp_q.size()), 32'h0);

        // 4: '1' and '2' together, then '1' alone
        do_reset();
        keys = (16'(1) << 0) | (16'(1) << 1);
        wait_to(80);
        chk("multi_no_held", 32'(key_held), 32'h0);
        chk("multi_value", 32'(key_value), 32'h0);
        keys = 16'(1) << 0;
        expect_key(4'h1, 128);
        wait_to(130); chk("k1_value", 32'(key_value), 32'h1);
        keys = '0;
        wait_to(190); chk("k1_drained", 32'(exp_q.size()), 32'h0);

        // 5: '8' with a short gap does not re-trigger
        do_reset();
        keys = 16'(1) << 9;
        expect_key(4'h8, 48);
        wait_to(48);  keys = '0;
        wait_to(64);  chk("k8_held_gap1", 32'(key_held), 32'h1);
        wait_to(79);  chk("k8_held_gap2", 32'(key_held), 32'h1);
        wait_to(80);  keys = 16'(1) << 9;
        wait_to(96);  chk("k8_held_again", 32'(key_held), 32'h1);
        wait_to(112); chk("k8_held_end", 32'(key_held), 32'h1);
        keys = '0;
        wait_to(159); chk("k8_held_last", 32'(key_held), 32'h1);
        wait_to(160); chk("k8_held_off", 32'(key_held), 32'h0);
        wait_to(200); chk("k8_drained", 32'(exp_q.size()), 32'h0);

        // 6: reset pulse while '9' is held
        do_reset();
        keys = 16'(1) << 10;
        expect_key(4'h9, 48);
        wait_to(70);
        chk("k9_held_pre", 32'(key_held), 32'h1);
        chk("k9_value_pre", 32'(key_value), 32'h9);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        t0 = cyc;
        chk("k9_rst_held", 32'(key_held), 32'h0);
        chk("k9_rst_value", 32'(key_value), 32'h0);
        chk("k9_rst_col", 32'(shift_col), 32'h1);
        expect_key(4'h9, 48);
        wait_to(47);  chk("k9_reheld_before", 32'(key_held), 32'h0);
        wait_to(48);  chk("k9_reheld_on", 32'(key_held), 32'h1);
        wait_to(70);  chk("k9_drained", 32'(exp_q.size()), 32'h0);
        keys = '0;
        wait_to(130);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
